mux_tree_pipe: RTL and testbench
================================

# mux_tree_pipe

Parametrised, pipelined 2^N_SEL:1 multiplexer tree for DW-bit channels, with a valid/ready handshake at both ends. Level L of the tree resolves select bit sel[L], least-significant bit first. Any subset of levels can be registered, so the block trades latency for timing. It replaces the fixed 8:1 single-bit combinational tree wherever wide, multi-channel selection must close timing in the datapath clock domain.

## Interface
- N_SEL, default 3: number of select bits and tree levels; channel count is 2^N_SEL; legal range 1..6.
- DW, default 8: bits per channel; legal range 1..64.
- REG_LEVELS, default all ones (N_SEL bits): bit L=1 registers the output of tree level L.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  d/sel beat is presented.
- in_ready  out  1  block accepts the beat this cycle.
- d  in  DW*2^N_SEL  channel i occupies d[i*DW +: DW].
- sel  in  N_SEL  channel index.
- out_valid  out  1  out_data holds a selected beat.
- out_ready  in  1  downstream accepts the beat this cycle.
- out_data  out  DW  selected channel value.

## Operation
- Level L reduces 2^(N_SEL-L) words to 2^(N_SEL-L-1) words. Each output word k is the word at index 2k+1 when sel[L]=1, otherwise the word at index 2k. The result is out_data = d[sel*DW +: DW].
- A registered level stores its reduced words, a valid bit, and the unused upper select bits sel[N_SEL-1:L+1]. Later levels use these carried select bits, never the live sel input.
- Per registered stage s: ready_s = !valid_s || ready_(s+1). The last stage uses out_ready. The ready chain is combinational end to end; there is no skid buffer.
- Stage s loads when its upstream valid is high and ready_s is high. On load, valid_s takes the upstream valid and data and select registers update.
- When the upstream is idle and the downstream accepts, valid_s clears and the data registers keep their old contents.
- Data registers change only on load. While out_valid=1 and out_ready=0, out_data and all stage contents are frozen.
- in_ready = ready of the first registered stage. With REG_LEVELS=0, in_ready=out_ready and out_valid=in_valid.
- Unregistered levels are pure combinational pass-through of data, valid, and select bits.
- Beats leave in acceptance order. No beat is dropped or duplicated.
- d and sel are sampled only in the cycle where in_valid and in_ready are both high.

## Timing
- Latency = popcount(REG_LEVELS) cycles from the accepting edge to out_valid. Zero registered levels gives a combinational path.
- Throughput is one beat per cycle while out_ready=1.
- Occupancy is at most popcount(REG_LEVELS) beats. With out_ready held low, in_ready falls in the cycle after the first stage fills while every later stage is full.
- Reset, asynchronous on the falling edge of rst_n: all valid bits, data registers, and select registers clear to 0. Consequences:
  - out_valid=0.
  - out_data=0 when the last level is registered; otherwise it follows inputs combinationally.
  - in_ready=1 for REG_LEVELS≠0; otherwise it equals out_ready.
- Reset mid-stream discards all in-flight beats; nothing is emitted after release.
- First acceptance is possible on the first rising edge with rst_n=1.
- Simultaneous load and drain of a full stage is a legal pass-through; the stage stays valid with new contents.
- sel values are all legal, since the channel count is exactly 2^N_SEL. No X propagates from sel when in_valid=0.

## Test plan
- Reset check: assert rst_n=0 with N_SEL=3, DW=8, REG_LEVELS=3'b111 and random inputs. Required: out_valid=0, out_data=8'h00, in_ready=1 throughout, including asynchronous assertion mid-cycle.
- Full select sweep: channel i = 8'hA0+i, sel stepped 0..7 on consecutive cycles, in_valid=1, out_ready=1. Required: out_data = A0..A7 in order, with out_valid first high 3 cycles after the first acceptance and continuous after that.
- Backpressure: stream sel=5,2,7,0 and hold out_ready=0 for 4 cycles once out_valid rises. Required: out_data stays 8'hA5 throughout and in_ready drops with 3 beats held. After release the outputs are A5,A2,A7,A0 with none lost.
- Combinational mode: REG_LEVELS=3'b000, sel=6. Required: out_data=8'hA6 in the same cycle, out_valid=in_valid, and in_ready tracks out_ready cycle by cycle.
- Sparse registering: REG_LEVELS=3'b010, sel changes every cycle. Required: 1-cycle latency, and out_data matches a model that uses the sel[2] value captured with the beat, not the live one.
- Mid-stream reset: pulse rst_n low for one cycle with 2 beats in flight. Required: out_valid=0 immediately and stays 0 until new beats are accepted after release; the next output is the first post-reset beat.

Source files
------------

// File: rtl/mux_tree_pipe.sv
// mux_tree_pipe: pipelined 2^N_SEL:1 multiplexer tree for DW-bit channels.
// Level L resolves sel[L] (LSB first). Levels whose REG_LEVELS bit is set
// hold their reduced words, a valid bit and the not-yet-used upper select
// bits; later levels steer from those carried bits, never from the live sel.
// The ready chain is combinational end to end, with no skid buffer.
module mux_tree_pipe #(
  parameter int               N_SEL      = 3,
  parameter int               DW         = 8,
  parameter logic [N_SEL-1:0] REG_LEVELS = '1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [(DW<<N_SEL)-1:0]    d,
  input  logic [N_SEL-1:0]          sel,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DW-1:0]             out_data
);

  genvar gi;

  for (gi = 0; gi < N_SEL; gi++) begin : g_lvl
    // Level gi consumes 2^(N_SEL-gi) words and produces half as many.
    localparam int HALF = 1 << (N_SEL - gi - 1);
    localparam int WI   = DW * (2 * HALF);
    localparam int WO   = DW * HALF;
    // Select bits still meaningful at this level: sel[N_SEL-1:gi].
    localparam int SW   = N_SEL - gi;

    logic [WI-1:0] data_in;
    logic [SW-1:0] sel_in;
    logic          valid_in;
    logic          ready_in;
    logic [WO-1:0] reduced;
    logic [WO-1:0] data_out;
    logic          valid_out;
    logic          ready_out;

    if (gi == 0) begin : g_src
      assign data_in  = d;
      assign sel_in   = sel;
      assign valid_in = in_valid;
    end else begin : g_src
      assign data_in  = g_lvl[gi-1].data_out;
      assign sel_in   = g_lvl[gi-1].g_up.sel_out;
      assign valid_in = g_lvl[gi-1].valid_out;
    end

    if (gi == N_SEL - 1) begin : g_dst
      assign ready_out = out_ready;
    end else begin : g_dst
      assign ready_out = g_lvl[gi+1].ready_in;
    end

    // Pairwise reduction: word k takes odd partner 2k+1 when this level's bit is set.
    always_comb begin
      reduced = '0;
      for (int k = 0; k < HALF; k++) begin
        reduced[k*DW +: DW] = sel_in[0] ? data_in[(2*k+1)*DW +: DW]
                                        : data_in[(2*k)*DW +: DW];
      end
    end

    if (REG_LEVELS[gi]) begin : g_reg
      logic          valid_q;
      logic [WO-1:0] data_q;

      // A stage can take a beat when empty or when its own beat leaves now.
      assign ready_in  = !valid_q || ready_out;
      assign valid_out = valid_q;
      assign data_out  = data_q;

      // Load on handshake; clear valid only when drained with nothing new arriving.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_q <= 1'b0;
          data_q  <= '0;
        end else if (valid_in && ready_in) begin
          valid_q <= 1'b1;
          data_q  <= reduced;
        end else if (ready_out) begin
          valid_q <= 1'b0;
        end
      end
    end else begin : g_reg
      assign ready_in  = ready_out;
      assign valid_out = valid_in;
      assign data_out  = reduced;
    end

    // Upper select bits travel alongside the data; the last level has none left.
    if (gi < N_SEL - 1) begin : g_up
      logic [SW-2:0] sel_out;
      if (REG_LEVELS[gi]) begin : g_sreg
        // Capture the remaining select bits with the beat so later levels ignore live sel.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            sel_out <= '0;
          end else if (valid_in && ready_in) begin
            sel_out <= sel_in[SW-1:1];
          end
        end
      end else begin : g_sreg
        assign sel_out = sel_in[SW-1:1];
      end
    end
  end

  assign in_ready  = g_lvl[0].ready_in;
  assign out_valid = g_lvl[N_SEL-1].valid_out;
  assign out_data  = g_lvl[N_SEL-1].data_out;

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Bench for mux_tree_pipe: three instances (fully registered, purely
// combinational, middle level registered) checked against an ordered queue
// of expected words computed as d shifted right by 8*sel.
module tb_mux_tree_pipe;

  localparam logic [63:0] RAMP = 64'hA7A6_A5A4_A3A2_A1A0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [63:0] a_d;
  logic [2:0]  a_sel;
  logic [7:0]  a_out_data;

  logic c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [63:0] c_d;
  logic [2:0]  c_sel;
  logic [7:0]  c_out_data;

  logic s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [63:0] s_d;
  logic [2:0]  s_sel;
  logic [7:0]  s_out_data;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] q_a[$];
  logic [7:0] q_s[$];

  mux_tree_pipe #(.N_SEL(3), .DW(8), .REG_LEVELS(3'b111)) u_full (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .d(a_d), .sel(a_sel), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data));

  mux_tree_pipe #(.N_SEL(3), .DW(8), .REG_LEVELS(3'b000)) u_comb (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .d(c_d), .sel(c_sel), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_data(c_out_data));

  mux_tree_pipe #(.N_SEL(3), .DW(8), .REG_LEVELS(3'b010)) u_sparse (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .d(s_d), .sel(s_sel), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_data(s_out_data));

  // Reference selection: channel sel is the byte sitting 8*sel bits up.
  function automatic logic [7:0] pick(input logic [63:0] dd, input logic [2:0] ss);
    logic [63:0] sh;
    sh = dd >> (8 * int'(ss));
    return sh[7:0];
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_in_valid = 1'($urandom); a_out_ready = 1'($urandom);
      a_d = {$urandom, $urandom}; a_sel = 3'($urandom);
      @(negedge clk);
      n_checks++; if (a_out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", a_out_valid); else n_pass++;
      n_checks++; if (a_out_data !== 8'h00) $display("FAIL reset_out_data: got %h want 00", a_out_data); else n_pass++;
      n_checks++; if (a_in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", a_in_ready); else n_pass++;
      next_cycle();
    end
    rst_n = 1'b1;
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_d = RAMP; a_sel = 3'd1;
    repeat (3) next_cycle();
    n_checks++; if (a_out_valid !== 1'b1 || a_out_data !== 8'hA1) $display("FAIL reset_prefill: got v=%b d=%h want v=1 d=a1", a_out_valid, a_out_data); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (a_out_valid !== 1'b0) $display("FAIL async_reset_out_valid: got %b want 0", a_out_valid); else n_pass++;
    n_checks++; if (a_out_data !== 8'h00) $display("FAIL async_reset_out_data: got %h want 00", a_out_data); else n_pass++;
    n_checks++; if (a_in_ready !== 1'b1) $display("FAIL async_reset_in_ready: got %b want 1", a_in_ready); else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1; a_in_valid = 1'b0; a_out_ready = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_sweep();
    logic [7:0] exp;
    q_a.delete();
    a_out_ready = 1'b1; a_d = RAMP;
    for (int t = 0; t < 14; t++) begin
      a_in_valid = (t < 8); a_sel = 3'(t);
      @(negedge clk);
      n_checks++; if (a_out_valid !== (t >= 3 && t < 11)) $display("FAIL sweep_valid t=%0d: got %b want %b", t, a_out_valid, (t >= 3 && t < 11)); else n_pass++;
      n_checks++; if (a_in_ready !== 1'b1) $display("FAIL sweep_in_ready t=%0d: got %b want 1", t, a_in_ready); else n_pass++;
      if (a_in_valid && a_in_ready) q_a.push_back(pick(a_d, a_sel));
      if (a_out_valid && a_out_ready) begin
        exp = (q_a.size() > 0) ? q_a.pop_front() : 8'hxx;
        n_checks++; if (a_out_data !== exp || a_out_data !== 8'(8'hA0 + t - 3)) $display("FAIL sweep_data t=%0d: got %h want %h", t, a_out_data, 8'(8'hA0 + t - 3)); else n_pass++;
      end
      next_cycle();
    end
    $display("test_sweep done");
  endtask

  task automatic test_backpressure();
    logic [2:0] sels [4];
    logic [7:0] exp;
    int idx, hold, outs;
    logic in_hold;
    sels[0] = 3'd5; sels[1] = 3'd2; sels[2] = 3'd7; sels[3] = 3'd0;
    idx = 0; hold = 0; outs = 0;
    q_a.delete(); a_d = RAMP;
    for (int t = 0; t < 20; t++) begin
      a_in_valid = (idx < 4); a_sel = sels[idx % 4];
      if (a_out_valid && hold < 4) begin a_out_ready = 1'b0; hold++; in_hold = 1'b1; end
      else begin a_out_ready = 1'b1; in_hold = 1'b0; end
      @(negedge clk);
      if (in_hold) begin
        n_checks++; if (a_out_valid !== 1'b1 || a_out_data !== 8'hA5) $display("FAIL bp_hold_data t=%0d: got v=%b d=%h want v=1 d=a5", t, a_out_valid, a_out_data); else n_pass++;
        n_checks++; if (a_in_ready !== 1'b0) $display("FAIL bp_in_ready t=%0d: got %b want 0", t, a_in_ready); else n_pass++;
      end
      if (a_in_valid && a_in_ready) begin q_a.push_back(pick(a_d, a_sel)); idx++; end
      if (a_out_valid && a_out_ready) begin
        exp = (q_a.size() > 0) ? q_a.pop_front() : 8'hxx;
        outs++;
        n_checks++; if (a_out_data !== exp) $display("FAIL bp_data out=%0d: got %h want %h", outs, a_out_data, exp); else n_pass++;
      end
      next_cycle();
    end
    n_checks++; if (outs !== 4 || hold !== 4) $display("FAIL bp_count: got outs=%0d hold=%0d want 4 4", outs, hold); else n_pass++;
    $display("test_backpressure done");
  endtask

  task automatic test_comb();
    for (int t = 0; t < 12; t++) begin
      c_in_valid = 1'($urandom); c_out_ready = 1'($urandom);
      if (t < 6) begin c_d = RAMP; c_sel = 3'd6; end
      else begin c_d = {$urandom, $urandom}; c_sel = 3'($urandom); end
      @(negedge clk);
      n_checks++; if (c_out_data !== ((t < 6) ? 8'hA6 : pick(c_d, c_sel))) $display("FAIL comb_data t=%0d: got %h want %h", t, c_out_data, pick(c_d, c_sel)); else n_pass++;
      n_checks++; if (c_out_valid !== c_in_valid) $display("FAIL comb_valid t=%0d: got %b want %b", t, c_out_valid, c_in_valid); else n_pass++;
      n_checks++; if (c_in_ready !== c_out_ready) $display("FAIL comb_ready t=%0d: got %b want %b", t, c_in_ready, c_out_ready); else n_pass++;
      next_cycle();
    end
    $display("test_comb done");
  endtask

  task automatic test_sparse();
    logic [7:0] exp;
    logic prev_acc;
    prev_acc = 1'b0; q_s.delete();
    for (int t = 0; t < 46; t++) begin
      s_in_valid = (t < 40) ? 1'($urandom) : 1'b0;
      s_out_ready = (t < 20 || t >= 40) ? 1'b1 : 1'($urandom);
      s_d = {$urandom, $urandom}; s_sel = 3'($urandom);
      @(negedge clk);
      if (t < 20) begin
        n_checks++; if (s_out_valid !== prev_acc) $display("FAIL sparse_latency t=%0d: got %b want %b", t, s_out_valid, prev_acc); else n_pass++;
      end
      prev_acc = s_in_valid && s_in_ready;
      if (s_in_valid && s_in_ready) q_s.push_back(pick(s_d, s_sel));
      if (s_out_valid && s_out_ready) begin
        exp = (q_s.size() > 0) ? q_s.pop_front() : 8'hxx;
        n_checks++; if (s_out_data !== exp) $display("FAIL sparse_data t=%0d: got %h want %h", t, s_out_data, exp); else n_pass++;
      end
      next_cycle();
    end
    n_checks++; if (q_s.size() !== 0) $display("FAIL sparse_drain: got %0d left want 0", q_s.size()); else n_pass++;
    $display("test_sparse done");
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    q_a.delete();
    for (int t = 0; t < 160; t++) begin
      a_in_valid = (t < 150) ? 1'($urandom) : 1'b0;
      a_out_ready = (t < 150) ? ($urandom_range(3) != 0) : 1'b1;
      a_d = {$urandom, $urandom}; a_sel = 3'($urandom);
      @(negedge clk);
      n_checks++; if (q_a.size() > 3) $display("FAIL b2b_occupancy t=%0d: got %0d want <=3", t, q_a.size()); else n_pass++;
      if (a_in_valid && a_in_ready) q_a.push_back(pick(a_d, a_sel));
      if (a_out_valid && a_out_ready) begin
        exp = (q_a.size() > 0) ? q_a.pop_front() : 8'hxx;
        n_checks++; if (a_out_data !== exp) $display("FAIL b2b_data t=%0d: got %h want %h", t, a_out_data, exp); else n_pass++;
      end
      next_cycle();
    end
    n_checks++; if (q_a.size() !== 0) $display("FAIL b2b_drain: got %0d left want 0", q_a.size()); else n_pass++;
    $display("test_back_to_back done");
  endtask

  task automatic test_midreset();
    a_out_ready = 1'b1; a_d = RAMP;
    a_in_valid = 1'b1; a_sel = 3'd4; next_cycle();
    a_sel = 3'd1; next_cycle();
    a_in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (a_out_valid !== 1'b0) $display("FAIL midrst_valid: got %b want 0", a_out_valid); else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int t = 0; t < 8; t++) begin
      a_in_valid = (t == 2); a_sel = 3'd3;
      @(negedge clk);
      n_checks++; if (a_out_valid !== (t == 5)) $display("FAIL midrst_after t=%0d: got %b want %b", t, a_out_valid, (t == 5)); else n_pass++;
      if (t == 5) begin
        n_checks++; if (a_out_data !== 8'hA3) $display("FAIL midrst_data: got %h want a3", a_out_data); else n_pass++;
      end
      next_cycle();
    end
    $display("test_midreset done");
  endtask

  initial begin
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_out_ready = 1'b0; a_d = '0; a_sel = '0;
    c_in_valid = 1'b0; c_out_ready = 1'b0; c_d = '0; c_sel = '0;
    s_in_valid = 1'b0; s_out_ready = 1'b0; s_d = '0; s_sel = '0;
    test_reset();
    test_sweep();
    test_backpressure();
    test_comb();
    test_sparse();
    test_back_to_back();
    test_midreset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
